// File: rtl/rr_onehot_arbiter_pkg.sv
// rr_onehot_arbiter_pkg: shared constants, state type and index-to-one-hot golden function
package rr_onehot_arbiter_pkg;
  localparam int N = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N-1:0] idx2onehot(input logic [IDX_W-1:0] i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// rr_onehot_arbiter_if: request/grant bundle; master = arbiter side, slave = requester/encoder side
interface rr_onehot_arbiter_if;
  import rr_onehot_arbiter_pkg::*;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic preempt;
  modport master(input req, output grant, grant_valid, grant_idx, preempt);
  modport slave(output req, input grant, grant_valid, grant_idx, preempt);
endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// rr_priority_pick: rotate req by ptr, take lowest set bit, unrotate to an absolute winner index
module rr_priority_pick
  import rr_onehot_arbiter_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [IDX_W-1:0] off;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
  end
  assign found = |req;
  assign win_idx = ptr + off;
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: 8-way round-robin arbiter with registered one-hot grant, index and hold-timeout preempt
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  rr_onehot_arbiter_if.master bus
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, w, w_n, win;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic found, rel, tmo, pre_n, valid_d;
  logic [N-1:0] grant_d, grant_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic valid_q, pre_q;
  rr_priority_pick u_pick (
    .req(bus.req),
    .ptr(ptr),
    .found(found),
    .win_idx(win)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      w <= '0;
      cnt <= '0;
      grant_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      pre_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      w <= w_n;
      cnt <= cnt_n;
      grant_q <= grant_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      pre_q <= pre_n;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    w_n = w;
    cnt_n = cnt;
    pre_n = 1'b0;
    rel = !bus.req[w];
    tmo = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD - 1));
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        w_n = win;
        cnt_n = '0;
      end
    end else if (rel || tmo) begin
      state_n = IDLE;
      ptr_n = w + IDX_W'(1);
      pre_n = !rel;
      cnt_n = '0;
    end else begin
      cnt_n = &cnt ? cnt : cnt + CNT_W'(1);
    end
  end
  always_comb begin
    valid_d = state_n == GRANT;
    grant_d = valid_d ? idx2onehot(w_n) : '0;
    idx_d = valid_d ? w_n : '0;
  end
  assign bus.grant = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.preempt = pre_q;
endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter for eight request lines. Produces a registered one-hot grant vector that feeds the 8:3 one-hot encoder stage directly downstream.
- Guarantees the encoder only ever sees all-zero or exactly-one-hot input.
- Also provides a registered binary grant index and a preemption pulse, so the encoder output can be cross-checked.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision to match the 8:3 encoder.
- IDX_W, 3, grant index width (log2 N).
- MAX_HOLD, 16, maximum consecutive grant cycles per requester; 0 = unlimited hold.
- CNT_W, 8, hold-counter width; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  N  request lines; a requester holds its bit high for as long as it needs the resource
- grant  output  N  registered one-hot grant; all-zero when idle
- grant_valid  output  1  high iff grant is nonzero
- grant_idx  output  IDX_W  binary index of the granted bit; 0 when idle
- preempt  output  1  one-cycle pulse on the first idle cycle after a MAX_HOLD timeout

Behaviour:
- Reset: all state updates only on rising clk.
  - rst_n low at an edge -> grant=0, grant_valid=0, grant_idx=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
  - Applies from any state, including mid-grant. No asynchronous path.
- State machine, two states, IDLE and GRANT:
  - IDLE, req==0 -> stay IDLE; outputs 0.
  - IDLE, req!=0 -> winner w = first set bit scanning ptr, ptr+1, ..., wrapping modulo N.
    - Next cycle: state=GRANT, grant=1<<w, grant_idx=w, grant_valid=1, hold_cnt=0.
    - Latency is one cycle from a req bit seen in IDLE to its grant.
  - GRANT, req[w]==0 -> next cycle: state=IDLE, outputs cleared, ptr=(w+1) mod N.
    - Other req bits are ignored while in GRANT; there is no preemption by others.
  - GRANT, req[w]==1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> next cycle: state=IDLE, outputs cleared, ptr=(w+1) mod N, preempt=1 for that one cycle.
    - A held grant therefore lasts exactly MAX_HOLD cycles.
  - GRANT otherwise -> hold grant; hold_cnt increments, saturating at all-ones.
- Bubble: every release or timeout inserts exactly one all-zero cycle. The earliest next grant appears two cycles after the cycle where the release was sampled.
- Fairness:
  - The pointer advances past the last winner only.
  - With all eight bits requesting continuously, grants rotate 0,1,...,7,0.
  - A timed-out sole requester is re-granted after the bubble, because the scan wraps back to it.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always equals the encoder mapping of grant.
  - grant_valid == |grant.
  - preempt is never high while grant_valid is high.
- Pointer arithmetic: ptr is IDX_W bits wide; N is a power of two, so the increment wraps naturally from 7 to 0.
- Simultaneous events: when req[w] drops in the same cycle hold_cnt reaches MAX_HOLD-1, this is treated as a normal release and preempt stays 0.

Decomposition:
- Shared package:
  - state enum (IDLE, GRANT)
  - N and IDX_W constants
  - a function converting an index to a one-hot vector, shared by this block and the encoder testbench as the golden model
- Sub-module rr_priority_pick (combinational): inputs req and ptr; outputs found and win_idx. It performs the rotate, priority-select and unrotate steps.
- All registers stay in the top-level block.

Test Plan:
- Reset, then req=8'b00100100 held -> cycle+1: grant=8'b00000100, grant_idx=2. Drop req[2] -> next cycle grant=0. The cycle after: grant=8'b00100000, grant_idx=5.
- Wrap-around: ptr=6 after granting bit 5, req=8'b00000011 -> grant=8'b00000001, grant_idx=0. After release -> grant=8'b00000010.
- Timeout with MAX_HOLD=4, req=8'b00000011 held -> bit0 granted exactly 4 cycles; 1 idle cycle with preempt=1; then grant=8'b00000010.
- Sole requester with MAX_HOLD=4, req=8'b00000001 held -> repeating pattern of 4 grant cycles, 1 idle cycle with preempt=1.
- All requesting, req=8'hFF with one-cycle releases -> grant_idx sequence 0..7,0. Checker asserts one-hot and the grant_idx/encoder match on every cycle.
- rst_n low for one edge while grant=8'b00010000 -> next cycle all outputs 0. req=8'b00010000 held through reset -> granted again one cycle after rst_n returns high (ptr=0 scan).
